inner_product_acc: RTL
======================

# inner_product_acc

Parametrised, pipelined fixed-point inner-product engine for the CNN datapath. It consumes a dot-product vector of arbitrary length as a stream of LANES-wide beats and accumulates partial sums across beats. It adds a per-vector bias, then rounds, saturates and optionally applies ReLU. Valid/ready handshakes on both sides let it sit between the window/weight feeders and the feature-map writer in conv and fully-connected layers.

## Interface
Parameters:
- DATA_WIDTH, 16: signed fixed-point width of operands, bias and result.
- FRAC_BITS, 8: fractional bits of operands, bias and result (Q(DW-FB).FB).
- LANES, 25: products per beat.
- ACC_WIDTH, 48: signed accumulator width; must be at least 2*DATA_WIDTH + clog2(LANES) + 8.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready at a rising edge.
- in_last  in  1  final beat of the current vector.
- in_vecA  in  LANES*DATA_WIDTH  signed operands; lane i is bits [i*DW +: DW].
- in_vecB  in  LANES*DATA_WIDTH  signed operands, same packing.
- bias  in  DATA_WIDTH  signed bias; sampled on the first beat of a vector only.
- relu_en  in  1  clamp negative results to 0; sampled on the first beat only.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_data  out  DATA_WIDTH  signed result.
- out_sat  out  1  result was saturated; valid with out_data.

## Operation
- Stage M: LANES signed products are formed at full 2*DW width and registered.
- Stage T: a registered binary adder tree of depth D = clog2(LANES) sign-extends to ACC_WIDTH. Odd leftovers pass through a register.
- Stage A, accumulator:
  - On the first beat of a vector: acc = tree_sum + (bias <<< FRAC_BITS).
  - On later beats: acc += tree_sum.
  - The "first" flag is set by reset and after each in_last beat.
- Stage O, applied on the in_last beat:
  - Add 2^(FRAC_BITS-1), round half up.
  - Arithmetic shift right by FRAC_BITS.
  - Saturate to [-2^(DW-1), 2^(DW-1)-1] and set out_sat if clamped.
  - If relu_en, a negative result gives 0 with out_sat=0.
  - Load out_data and set out_valid.
- A valid bit, a last bit and the sampled relu_en travel with each beat through every stage.
- Vectors of one beat (in_last on the first beat) are legal. There is no maximum beat count.
- Stall: stall = out_valid && !out_ready. When stalled, all pipeline registers and the accumulator hold, and in_ready = !stall.
  - A final result arriving at stage O while out_valid is held would be lost; the global stall prevents this.
  - When out_ready is high, a new result may load in the same cycle the old one is consumed.
- Reset (rst_n low at an edge) clears all valid bits, out_valid, out_data, out_sat and the accumulator, and sets "first". A partially accumulated vector is discarded.

## Timing
- Reset values: in_ready=1 on the first cycle after reset deassert; out_valid=0, out_data=0, out_sat=0.
- Latency: the last beat is accepted at edge t, and out_valid rises after edge t+D+2.
  - Default LANES=25 gives D=5, so out_valid is high 7 cycles after acceptance.
- Throughput: one beat per cycle while not stalled. Back-to-back vectors need no bubble.
- out_data, out_sat and out_valid are registered outputs. in_ready is combinational from out_valid and out_ready only.
- Once raised, out_valid stays high with stable data until consumed.
- in_valid low inserts a bubble. The accumulator holds and the partial vector is preserved.

## Structure
- A shared package cnn_pkg holds:
  - the clog2 function;
  - the default DATA_WIDTH and FRAC_BITS constants;
  - the saturating round-shift function (acc, FRAC_BITS to DATA_WIDTH, with a saturation flag).
- One sub-module: add_tree_pipe (parameters LANES, IN_W, OUT_W, registered per level, with a shared enable), for reuse by pooling and FC blocks.
- The multipliers, accumulator, output stage and handshake live in the top module.

## Test plan
All scenarios use the defaults. 1.0 = 0x0100.
- Single beat, all A=0x0100, B=0x0100, bias=0, out_ready=1 -> out_data=0x1900 and out_sat=0, exactly 7 cycles after acceptance.
- Three-beat vector, A=0x0100, B=0x0080, bias=0x0100, with a 2-cycle in_valid gap between beats 2 and 3 -> out_data=0x2680 (38.5).
- Rounding: one lane A=0x0001, B=0x0080, other lanes 0 -> out_data=0x0001. With B=0xFF80 -> 0x0000.
- Saturation: all A=B=0x7FFF -> 0x7FFF with out_sat=1. A=0x7FFF, B=0x8000 -> 0x8000 with out_sat=1.
- ReLU: A=0x0100, B=0xFF00, bias=0 -> 0x0000 with relu_en=1. The same vector with relu_en=0 -> 0xE700.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles with 4 single-beat vectors offered -> in_ready drops, all 4 results delivered in order, none duplicated.
  - Pulse rst_n low after 2 beats of a 3-beat vector -> out_valid=0, and the next vector's result is unaffected by the discarded partial sum.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN datapath helpers: default fixed-point format, clog2 and the
// round/shift/saturate step used when narrowing accumulators to results.
package cnn_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_FRAC_BITS  = 8;

  // Fixed working widths for the saturating helper; callers sign-extend into
  // SAT_IN_W and take the low DATA_WIDTH bits of the returned value.
  localparam int SAT_IN_W  = 128;
  localparam int SAT_OUT_W = 64;

  typedef struct packed {
    logic signed [SAT_OUT_W-1:0] value;
    logic                        sat;
  } sat_result_t;

  function automatic int clog2(input int n);
    int r = 0;
    int v = 1;
    while (v < n) begin
      v = v * 2;
      r++;
    end
    return r;
  endfunction

  // Round half up, drop frac_bits, clamp to a data_width signed range.
  function automatic sat_result_t sat_round_shift(
    input logic signed [SAT_IN_W-1:0] acc,
    input int                         frac_bits,
    input int                         data_width
  );
    logic signed [SAT_IN_W-1:0] half;
    logic signed [SAT_IN_W-1:0] rounded;
    logic signed [SAT_IN_W-1:0] shifted;
    logic signed [SAT_IN_W-1:0] max_v;
    logic signed [SAT_IN_W-1:0] min_v;
    logic signed [SAT_IN_W-1:0] clamped;
    sat_result_t                res;
    half    = (frac_bits > 0) ? (SAT_IN_W'(1) <<< (frac_bits - 1)) : '0;
    rounded = acc + half;
    shifted = rounded >>> frac_bits;
    max_v   = (SAT_IN_W'(1) <<< (data_width - 1)) - 1;
    min_v   = -max_v - 1;
    res.sat = 1'b0;
    clamped = shifted;
    if (shifted > max_v) begin
      clamped = max_v;
      res.sat = 1'b1;
    end else if (shifted < min_v) begin
      clamped = min_v;
      res.sat = 1'b1;
    end
    res.value = clamped[SAT_OUT_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/add_tree_pipe.sv
// Pipelined binary adder tree: sign-extends LANES inputs to OUT_W and sums
// them over clog2(LANES) registered levels. Odd leftovers pass through a
// register so every path has the same latency. One enable freezes all levels.
module add_tree_pipe
  import cnn_pkg::*;
#(
  parameter int LANES = 25,
  parameter int IN_W  = 32,
  parameter int OUT_W = 48
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic [LANES*IN_W-1:0]   in_data,
  output logic signed [OUT_W-1:0] sum
);

  localparam int DEPTH = clog2(LANES);

  function automatic int level_count(input int level);
    int n = LANES;
    for (int k = 0; k < level; k++) begin
      n = (n + 1) / 2;
    end
    return n;
  endfunction

  genvar lv, j;
  for (lv = 0; lv <= DEPTH; lv++) begin : g_level
    localparam int N = level_count(lv);
    logic signed [OUT_W-1:0] node [0:N-1];

    if (lv == 0) begin : g_leaf
      for (j = 0; j < N; j++) begin : g_ext
        assign node[j] = OUT_W'($signed(in_data[j*IN_W +: IN_W]));
      end
    end else begin : g_sum
      localparam int NP = level_count(lv - 1);
      for (j = 0; j < N; j++) begin : g_node
        if (2 * j + 1 < NP) begin : g_pair
          // Register the sum of two children from the previous level.
          always_ff @(posedge clk) begin
            if (en) node[j] <= g_level[lv-1].node[2*j] + g_level[lv-1].node[2*j+1];
          end
        end else begin : g_pass
          // Register an unpaired child so it stays aligned with its peers.
          always_ff @(posedge clk) begin
            if (en) node[j] <= g_level[lv-1].node[2*j];
          end
        end
      end
    end
  end

  assign sum = g_level[DEPTH].node[0];

endmodule

// File: rtl/inner_product_acc.sv
// Streaming fixed-point inner product: LANES products per beat, adder tree,
// cross-beat accumulator with per-vector bias, then round/saturate/ReLU.
// A single global stall (result held and not taken) freezes the whole pipe.
module inner_product_acc
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FRAC_BITS  = DEFAULT_FRAC_BITS,
  parameter int LANES      = 25,
  parameter int ACC_WIDTH  = 48
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic [LANES*DATA_WIDTH-1:0]  in_vecA,
  input  logic [LANES*DATA_WIDTH-1:0]  in_vecB,
  input  logic [DATA_WIDTH-1:0]        bias,
  input  logic                         relu_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_sat
);

  localparam int DEPTH  = clog2(LANES);
  localparam int PROD_W = 2 * DATA_WIDTH;

  logic stall;
  logic en;
  logic accept;

  assign stall    = out_valid && !out_ready;
  assign en       = !stall;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  logic first_q;
  logic relu_hold;
  logic beat_relu;

  assign beat_relu = first_q ? relu_en : relu_hold;

  // Track vector boundaries and latch relu_en from each vector's first beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_q   <= 1'b1;
      relu_hold <= 1'b0;
    end else if (accept) begin
      first_q <= in_last;
      if (first_q) relu_hold <= relu_en;
    end
  end

  logic [LANES*PROD_W-1:0] prod_q;

  // Stage M: full-width signed products of every lane.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < LANES; i++) begin
        prod_q[i*PROD_W +: PROD_W] <= PROD_W'($signed(in_vecA[i*DATA_WIDTH +: DATA_WIDTH]))
                                    * PROD_W'($signed(in_vecB[i*DATA_WIDTH +: DATA_WIDTH]));
      end
    end
  end

  logic [DEPTH:0]               sb_valid;
  logic [DEPTH:0]               sb_last;
  logic [DEPTH:0]               sb_first;
  logic [DEPTH:0]               sb_relu;
  logic signed [DATA_WIDTH-1:0] sb_bias [0:DEPTH];

  // Beat valid bits through stage M and every tree level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb_valid <= '0;
    end else if (en) begin
      sb_valid[0] <= accept;
      for (int s = 1; s <= DEPTH; s++) sb_valid[s] <= sb_valid[s-1];
    end
  end

  // Per-beat sideband (last, first, relu, bias) aligned with the data path.
  always_ff @(posedge clk) begin
    if (en) begin
      sb_last[0]  <= in_last;
      sb_first[0] <= first_q;
      sb_relu[0]  <= beat_relu;
      sb_bias[0]  <= bias;
      for (int s = 1; s <= DEPTH; s++) begin
        sb_last[s]  <= sb_last[s-1];
        sb_first[s] <= sb_first[s-1];
        sb_relu[s]  <= sb_relu[s-1];
        sb_bias[s]  <= sb_bias[s-1];
      end
    end
  end

  logic signed [ACC_WIDTH-1:0] tree_sum;

  add_tree_pipe #(
    .LANES (LANES),
    .IN_W  (PROD_W),
    .OUT_W (ACC_WIDTH)
  ) u_tree (
    .clk     (clk),
    .en      (en),
    .in_data (prod_q),
    .sum     (tree_sum)
  );

  logic signed [ACC_WIDTH-1:0] bias_aligned;
  logic signed [ACC_WIDTH-1:0] acc;
  logic                        acc_valid;
  logic                        acc_last;
  logic                        acc_relu;

  assign bias_aligned = ACC_WIDTH'(sb_bias[DEPTH]) <<< FRAC_BITS;

  // Stage A: start a new sum with bias on the first beat, else accumulate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      acc_valid <= 1'b0;
      acc_last  <= 1'b0;
      acc_relu  <= 1'b0;
    end else if (en) begin
      acc_valid <= sb_valid[DEPTH];
      acc_last  <= sb_last[DEPTH];
      acc_relu  <= sb_relu[DEPTH];
      if (sb_valid[DEPTH]) begin
        acc <= sb_first[DEPTH] ? (tree_sum + bias_aligned) : (acc + tree_sum);
      end
    end
  end

  sat_result_t           rounded;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  res_sat;

  assign rounded = sat_round_shift(SAT_IN_W'(acc), FRAC_BITS, DATA_WIDTH);

  // ReLU overrides a negative (possibly clamped) result with a clean zero.
  always_comb begin
    res_data = rounded.value[DATA_WIDTH-1:0];
    res_sat  = rounded.sat;
    if (acc_relu && rounded.value[SAT_OUT_W-1]) begin
      res_data = '0;
      res_sat  = 1'b0;
    end
  end

  // Stage O: publish the finished vector; a new result may replace a consumed one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (en) begin
      out_valid <= acc_valid && acc_last;
      if (acc_valid && acc_last) begin
        out_data <= res_data;
        out_sat  <= res_sat;
      end
    end
  end

endmodule
